// File: rtl/cache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped byte cache.
package cache_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/cache_controller_if.sv
// CPU request/response and RAM read/write signals of the cache controller.
interface cache_controller_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_busy;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_write_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_read_data,
    output cpu_rdata, cpu_ready, cpu_busy, ram_read_en, ram_read_addr,
           ram_write_en, ram_write_addr, ram_write_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_read_data,
    input  cpu_rdata, cpu_ready, cpu_busy, ram_read_en, ram_read_addr,
           ram_write_en, ram_write_addr, ram_write_data
  );
endinterface

// File: rtl/cache_tag_array.sv
// Valid/tag/data storage: combinational lookup port, clocked update port.
// Only the valid bits are reset; tag and data are meaningless while invalid.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 3
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [INDEX_W-1:0] lookupIndex,
  output logic               lookupValid,
  output logic [TAG_W-1:0]   lookupTag,
  output logic [DATA_W-1:0]  lookupData,
  input  logic               updEn,
  input  logic [INDEX_W-1:0] updIndex,
  input  logic [TAG_W-1:0]   updTag,
  input  logic [DATA_W-1:0]  updData
);
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] lines [LINES];

  assign lookupValid = valid[lookupIndex];
  assign lookupTag   = tags[lookupIndex];
  assign lookupData  = lines[lookupIndex];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      valid <= '0;
    end else if (updEn) begin
      valid[updIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (updEn) begin
      tags[updIndex]  <= updTag;
      lines[updIndex] <= updData;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate byte cache; read hit ready 2 edges, write 3, miss 2+FILL_WAIT.
// Requests are only accepted in IDLE (cpu_busy otherwise); CACHE_STATS_EN adds hit_count/miss_count.
module cache_controller
  import cache_pkg::*;
#(
  parameter int LINES     = 8,
  parameter int FILL_WAIT = 1
) (
  input  logic               clk,
  input  logic               Reset,
  cache_controller_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  state_t            state, nextState;
  logic [ADDR_W-1:0] reqAddr;
  logic              reqWe;
  logic [DATA_W-1:0] reqWdata;
  logic [2:0]        fillCnt;
  logic              fillLast;
  logic              lineValid;
  logic [TAG_W-1:0]  lineTag;
  logic [DATA_W-1:0] lineData;
  logic              hit;
  logic              updEn;
  logic [DATA_W-1:0] updData;
  logic [DATA_W-1:0] rdata;

  cache_tag_array #(
    .LINES  (LINES),
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) tagArray (
    .clk        (clk),
    .Reset      (Reset),
    .lookupIndex(reqAddr[INDEX_W-1:0]),
    .lookupValid(lineValid),
    .lookupTag  (lineTag),
    .lookupData (lineData),
    .updEn      (updEn),
    .updIndex   (reqAddr[INDEX_W-1:0]),
    .updTag     (reqAddr[ADDR_W-1:INDEX_W]),
    .updData    (updData)
  );

  assign hit      = lineValid && (lineTag == reqAddr[ADDR_W-1:INDEX_W]);
  assign fillLast = (fillCnt == 3'(FILL_WAIT - 1));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Hit is re-evaluated in WRITE; the line cannot change between LOOKUP and WRITE.
  always_comb begin
    nextState = state;
    updEn     = 1'b0;
    updData   = reqWdata;
    case (state)
      IDLE:    if (bus.cpu_req) nextState = LOOKUP;
      LOOKUP:  if (reqWe)       nextState = WRITE;
               else if (hit)  nextState = DONE;
               else           nextState = FILL;
      FILL:    if (fillLast) begin
                 nextState = DONE;
                 updEn     = 1'b1;
                 updData   = bus.ram_read_data;
               end
      WRITE:   begin
                 nextState = DONE;
                 updEn     = hit;
               end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      reqAddr  <= '0;
      reqWe    <= 1'b0;
      reqWdata <= '0;
      fillCnt  <= '0;
      rdata    <= '0;
    end else begin
      if (state == IDLE && bus.cpu_req) begin
        reqAddr  <= bus.cpu_addr;
        reqWe    <= bus.cpu_we;
        reqWdata <= bus.cpu_wdata;
      end
      fillCnt <= (state == FILL) ? fillCnt + 3'd1 : 3'd0;
      if (state == LOOKUP && !reqWe && hit) rdata <= lineData;
      if (state == FILL && fillLast)        rdata <= bus.ram_read_data;
    end
  end

  assign bus.cpu_rdata      = rdata;
  assign bus.cpu_ready      = (state == DONE);
  assign bus.cpu_busy       = (state != IDLE);
  assign bus.ram_read_en    = (state == FILL);
  assign bus.ram_read_addr  = reqAddr;
  assign bus.ram_write_en   = (state == WRITE);
  assign bus.ram_write_addr = reqAddr;
  assign bus.ram_write_data = reqWdata;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a zero-clearing RAM model.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int LINES    = 8;
  localparam int FW       = 1;
  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = 2 + FW;
  localparam int WR_LAT   = 3;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0] mem [64];

  int         lat, rdCyc, wrCyc, both, readyCnt;
  logic [5:0] rdAddr, wrAddr;
  logic [7:0] wrData, rdata;

  cache_controller_if cif();
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller #(.LINES(LINES), .FILL_WAIT(FW)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (cif)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (cif.ram_write_en) begin
      mem[cif.ram_write_addr] <= cif.ram_write_data;
    end
  end

  assign cif.ram_read_data = cif.ram_read_en ? mem[cif.ram_read_addr] : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one request and records RAM activity until cpu_ready, then steps back to IDLE.
  task automatic access(input string tag, input logic we, input logic [5:0] addr,
                        input logic [7:0] wdata);
    lat = 0; rdCyc = 0; wrCyc = 0; both = 0;
    rdAddr = '0; wrAddr = '0; wrData = '0;
    cif.cpu_req = 1'b1; cif.cpu_we = we; cif.cpu_addr = addr; cif.cpu_wdata = wdata;
    @(posedge clk); #1;
    cif.cpu_req = 1'b0;
    lat = 1;
    while (cif.cpu_ready !== 1'b1 && lat < 20) begin
      if (cif.ram_read_en)  begin rdCyc++; rdAddr = cif.ram_read_addr; end
      if (cif.ram_write_en) begin wrCyc++; wrAddr = cif.ram_write_addr; wrData = cif.ram_write_data; end
      if (cif.ram_read_en && cif.ram_write_en) both++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = cif.cpu_rdata;
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, cif.cpu_ready, 0);
    check({tag, "_busy_drop"}, cif.cpu_busy, 0);
    check({tag, "_both_en"}, both, 0);
  endtask

  task automatic readChk(input string tag, input logic [5:0] addr, input logic [7:0] expData,
                         input logic expHit);
    access(tag, 1'b0, addr, 8'h00);
    check({tag, "_lat"}, lat, expHit ? HIT_LAT : MISS_LAT);
    check({tag, "_rd_cycles"}, rdCyc, expHit ? 0 : FW);
    if (!expHit) check({tag, "_rd_addr"}, rdAddr, addr);
    check({tag, "_rdata"}, rdata, expData);
    check({tag, "_wr_cycles"}, wrCyc, 0);
  endtask

  task automatic writeChk(input string tag, input logic [5:0] addr, input logic [7:0] data,
                          input logic [7:0] prevRdata);
    access(tag, 1'b1, addr, data);
    check({tag, "_lat"}, lat, WR_LAT);
    check({tag, "_wr_cycles"}, wrCyc, 1);
    check({tag, "_wr_addr"}, wrAddr, addr);
    check({tag, "_wr_data"}, wrData, data);
    check({tag, "_rd_cycles"}, rdCyc, 0);
    check({tag, "_rdata_kept"}, rdata, prevRdata);
  endtask

  task automatic statsChk(input string tag, input int expHit, input int expMiss);
`ifdef CACHE_STATS_EN
    check({tag, "_hit_count"}, hit_count, expHit);
    check({tag, "_miss_count"}, miss_count, expMiss);
`else
    check({tag, "_idle"}, cif.cpu_busy, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = '0; cif.cpu_wdata = '0;
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cif.cpu_ready, 0);
    check("rst_busy", cif.cpu_busy, 0);
    check("rst_rd_en", cif.ram_read_en, 0);
    check("rst_wr_en", cif.ram_write_en, 0);
    check("rst_rdata", cif.cpu_rdata, 0);
    check("rst_rd_addr", cif.ram_read_addr, 0);
    check("rst_wr_addr", cif.ram_write_addr, 0);
    check("rst_wr_data", cif.ram_write_data, 0);
    statsChk("rst", 0, 0);
    Reset = 1'b0;
    @(posedge clk); #1;

    // Cold read miss returns cleared memory.
    readChk("r041", 6'h05, 8'h00, 1'b0);

    doReset();
    writeChk("w042", 6'h05, 8'hA5, 8'h00);
    readChk("r042_miss", 6'h05, 8'hA5, 1'b0);
    readChk("r042_hit", 6'h05, 8'hA5, 1'b1);
    statsChk("s042", 1, 2);

    // 0x05 and 0x0D share index 5 with different tags.
    writeChk("w043", 6'h0D, 8'h3C, 8'hA5);
    readChk("r043_hit", 6'h05, 8'hA5, 1'b1);
    readChk("r043_evict", 6'h0D, 8'h3C, 1'b0);
    readChk("r043_again", 6'h05, 8'hA5, 1'b0);
    writeChk("whit", 6'h05, 8'h5A, 8'hA5);
    readChk("rwhit", 6'h05, 8'h5A, 1'b1);
    writeChk("w3f", 6'h3F, 8'h99, 8'h5A);
    readChk("r3f_miss", 6'h3F, 8'h99, 1'b0);
    readChk("r3f_hit", 6'h3F, 8'h99, 1'b1);
    readChk("r07_tag", 6'h07, 8'h00, 1'b0);
    statsChk("s043", 5, 8);

    // Request held high while busy, with a write to 0x3F, must not be queued.
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 6'h15; cif.cpu_wdata = 8'h00;
    @(posedge clk); #1;
    cif.cpu_we = 1'b1; cif.cpu_addr = 6'h3F; cif.cpu_wdata = 8'hEE;
    lat = 1; wrCyc = 0;
    while (cif.cpu_ready !== 1'b1 && lat < 20) begin
      if (cif.ram_write_en) wrCyc++;
      @(posedge clk); #1;
      lat++;
    end
    cif.cpu_req = 1'b0;
    check("busy_req_lat", lat, MISS_LAT);
    check("busy_req_rdata", cif.cpu_rdata, 8'h00);
    repeat (4) begin
      @(posedge clk); #1;
      if (cif.ram_write_en || cif.cpu_busy) wrCyc++;
    end
    check("busy_req_ignored", wrCyc, 0);
    check("busy_req_mem", mem[63], 8'h99);
    statsChk("s045", 5, 9);

    // Reset in the middle of a fill.
    cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 6'h2A;
    @(posedge clk); #1;
    cif.cpu_req = 1'b0;
    @(posedge clk); #1;
    check("r044_fill_en", cif.ram_read_en, 1);
    Reset = 1'b1;
    #1;
    check("r044_rd_en_drop", cif.ram_read_en, 0);
    check("r044_busy_drop", cif.cpu_busy, 0);
    @(posedge clk); #1;
    Reset = 1'b0;
    statsChk("s044_rst", 0, 0);
    readyCnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cif.cpu_ready) readyCnt++;
    end
    check("r044_no_ready", readyCnt, 0);
    readChk("r044_after", 6'h2A, 8'h00, 1'b0);
    statsChk("s044", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
